branch_predict_resolve: RTL
===========================

// Module: branch_predict_resolve
// PURPOSE
//  Parametrised branch unit: IF-stage direction/target prediction (tagged BTB + 2-bit counters) and
//  ID-stage resolution with signed/unsigned compare, mispredict detection and table training.
//  Sits between the fetch PC mux (Pred_*) and the ID/hazard unit (Redirect_o/Flush_o).
//  Table updates are registered; lookup and resolution are combinational.
// PARAMETERS
//  XLEN      32     data/address width
//  ENTRIES   16     BTB/counter entries; power of 2, >=2; IDX_W = $clog2(ENTRIES)
//  TAG_W     8      tag bits taken from PC[IDX_W+2 +: TAG_W]
//  CTR_INIT  2'b01  counter value loaded on reset (weakly not-taken)
// PORTS
//  clk_i              in   1     clock, rising edge
//  rst_i              in   1     reset; asynchronous, active-high
//  IF_PC_i            in   XLEN  fetch PC
//  Pred_Taken_o       out  1     predict taken for IF_PC_i
//  Pred_Target_o      out  XLEN  predicted target (IF_PC_i+4 when not taken)
//  ID_Valid_i         in   1     ID holds a real instruction
//  Stall_i            in   1     ID stalled; blocks table update
//  ID_PC_i            in   XLEN  PC of ID instruction
//  ID_Rs1_i/ID_Rs2_i  in   XLEN  forwarded operands
//  ID_Immediate_i     in   XLEN  sign-extended immediate
//  ID_ComparitorOp_i  in   3     `EQ/`NE/`LT/`GE/`LTU/`GEU
//  ID_BranchE_i       in   1     conditional branch
//  ID_JumpE_i         in   1     JAL/JALR
//  ID_isJALR_i        in   1     target = Rs1+imm instead of PC+imm
//  ID_PredTaken_i     in   1     prediction carried down pipe with this instr
//  ID_PredTarget_i    in   XLEN  predicted target carried down pipe
//  Redirect_o         out  1     mispredict: fetch from Redirect_target_o
//  Redirect_target_o  out  XLEN  corrected next PC
//  Flush_o            out  1     kill IF/ID contents (== Redirect_o)
// BEHAVIOUR
//  State per entry: valid, tag[TAG_W], isJump, target[XLEN], ctr[2]. Index = PC[IDX_W+1:2].
//  Lookup: hit = valid & tag match. Pred_Taken_o = hit & (isJump | ctr[1]). Miss -> not taken.
//  Compare: LT/GE signed ($signed), LTU/GEU unsigned, EQ/NE bitwise; other codes -> not taken.
//  taken = ID_JumpE_i | (ID_BranchE_i & cmp). target = isJALR ? (Rs1+imm)&~1 : PC+imm; mod 2^XLEN.
//  Mispredict = ID_Valid_i & (taken != ID_PredTaken_i | (taken & target != ID_PredTarget_i)).
//  Non-branch instr predicted taken (alias) -> mispredict, Redirect_target_o = ID_PC_i+4.
//  Redirect_target_o = taken ? target : ID_PC_i+4. Redirect_o/Flush_o valid only while ID_Valid_i.
//  Redirect is a same-cycle combinational output; Stall_i does not suppress it.
//  Update (posedge, enable = ID_Valid_i & ~Stall_i & (BranchE|JumpE)):
//   hit: ctr saturating +1 if taken else -1 (no wrap past 3/0); target, isJump rewritten.
//   miss & taken: allocate/overwrite entry, valid=1, ctr=2'b10, tag/target/isJump written.
//   miss & not taken: no write.
//  Simultaneous lookup and update of same index: lookup returns pre-update contents (no bypass).
//  Reset (async, any time incl. mid-update): all valid=0, ctr=CTR_INIT; pending update lost.
//  Outputs during/after reset: Pred_Taken_o=0, Pred_Target_o=IF_PC_i+4; Redirect_o/Flush_o=0 unless ID_Valid_i.
// CONFIGURATION
//  BRANCH_STATS_EN defined: adds ports Stat_branches_o, Stat_mispredicts_o (out, 32 each).
//   Branches +1 per update-enable cycle; mispredicts +1 when also Redirect_o. Wrap at 2^32; reset 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset, IF_PC_i=0x100 -> Pred_Taken_o=0, Pred_Target_o=0x104.
//  2 BEQ @0x100 imm=0x20 Rs1=Rs2=5, pred 0 -> Redirect_o=1, target 0x120; next cycle IF_PC_i=0x100 -> Pred_Taken_o=1, Pred_Target_o=0x120.
//  3 BLT Rs1=0xFFFFFFFF Rs2=1 -> taken; BLTU same operands -> not taken, Redirect_target_o=PC+4.
//  4 Same branch trained taken 4x then not-taken 1x -> ctr 3->2, still predicts taken; 2nd not-taken -> predicts not taken.
//  5 JALR Rs1=0x2001 imm=0x10 -> target 0x2010; Stall_i=1 same cycle -> Redirect_o=1, table unchanged.
//  6 Assert rst_i between update cycles -> all lookups miss; with BRANCH_STATS_EN counters read 0.

Source files
------------

// File: rtl/branch_predict_resolve.sv
// Branch unit: tagged BTB + 2-bit counter prediction at IF, compare/mispredict/training at ID.
// Optional BRANCH_STATS_EN adds free-running branch and mispredict counters.
module branch_predict_resolve #(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 16,
    parameter int         TAG_W    = 8,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] IF_PC_i,
    output logic            Pred_Taken_o,
    output logic [XLEN-1:0] Pred_Target_o,
    input  logic            ID_Valid_i,
    input  logic            Stall_i,
    input  logic [XLEN-1:0] ID_PC_i,
    input  logic [XLEN-1:0] ID_Rs1_i,
    input  logic [XLEN-1:0] ID_Rs2_i,
    input  logic [XLEN-1:0] ID_Immediate_i,
    input  logic [2:0]      ID_ComparitorOp_i,
    input  logic            ID_BranchE_i,
    input  logic            ID_JumpE_i,
    input  logic            ID_isJALR_i,
    input  logic            ID_PredTaken_i,
    input  logic [XLEN-1:0] ID_PredTarget_i,
    output logic            Redirect_o,
    output logic [XLEN-1:0] Redirect_target_o,
    output logic            Flush_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     Stat_branches_o,
    output logic [31:0]     Stat_mispredicts_o
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b100;
    localparam logic [2:0] OP_GE  = 3'b101;
    localparam logic [2:0] OP_LTU = 3'b110;
    localparam logic [2:0] OP_GEU = 3'b111;

    logic            valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic            jump_q   [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];
    logic [1:0]      ctr_q    [ENTRIES];

    // IF-stage lookup reads registered contents only; same-cycle updates are not bypassed.
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx        = IF_PC_i[IDX_W+1:2];
    assign if_tag        = IF_PC_i[IDX_W+2 +: TAG_W];
    assign if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign Pred_Taken_o  = if_hit && (jump_q[if_idx] || ctr_q[if_idx][1]);
    assign Pred_Target_o = Pred_Taken_o ? target_q[if_idx] : IF_PC_i + XLEN'(4);

    logic            cmp_true;
    logic            res_taken;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] res_target;
    logic [XLEN-1:0] id_pc_plus4;
    logic            mispredict;

    always_comb begin
        cmp_true = 1'b0;
        case (ID_ComparitorOp_i)
            OP_EQ:   cmp_true = (ID_Rs1_i == ID_Rs2_i);
            OP_NE:   cmp_true = (ID_Rs1_i != ID_Rs2_i);
            OP_LT:   cmp_true = ($signed(ID_Rs1_i) <  $signed(ID_Rs2_i));
            OP_GE:   cmp_true = ($signed(ID_Rs1_i) >= $signed(ID_Rs2_i));
            OP_LTU:  cmp_true = (ID_Rs1_i <  ID_Rs2_i);
            OP_GEU:  cmp_true = (ID_Rs1_i >= ID_Rs2_i);
            default: cmp_true = 1'b0;
        endcase
    end

    assign res_taken   = ID_JumpE_i || (ID_BranchE_i && cmp_true);
    assign jalr_sum    = ID_Rs1_i + ID_Immediate_i;
    assign res_target  = ID_isJALR_i ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0})
                                     : (ID_PC_i + ID_Immediate_i);
    assign id_pc_plus4 = ID_PC_i + XLEN'(4);

    // Covers wrong direction, wrong target, and non-branches that aliased to a taken entry.
    assign mispredict = ID_Valid_i &&
                        ((res_taken != ID_PredTaken_i) ||
                         (res_taken && (res_target != ID_PredTarget_i)));

    assign Redirect_o        = mispredict;
    assign Flush_o           = mispredict;
    assign Redirect_target_o = res_taken ? res_target : id_pc_plus4;

    logic [IDX_W-1:0] id_idx;
    logic [TAG_W-1:0] id_tag;
    logic             upd_en;
    logic             upd_hit;
    logic             upd_write;

    assign id_idx    = ID_PC_i[IDX_W+1:2];
    assign id_tag    = ID_PC_i[IDX_W+2 +: TAG_W];
    assign upd_en    = ID_Valid_i && !Stall_i && (ID_BranchE_i || ID_JumpE_i);
    assign upd_hit   = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
    assign upd_write = upd_en && (upd_hit || res_taken);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                if (res_taken && ctr_q[id_idx] != 2'b11)
                    ctr_q[id_idx] <= ctr_q[id_idx] + 2'd1;
                else if (!res_taken && ctr_q[id_idx] != 2'b00)
                    ctr_q[id_idx] <= ctr_q[id_idx] - 2'd1;
            end else if (res_taken) begin
                valid_q[id_idx] <= 1'b1;
                ctr_q[id_idx]   <= 2'b10;
            end
        end
    end

    // Payload needs no reset: it is only observed behind valid_q.
    always_ff @(posedge clk_i) begin
        if (upd_write) begin
            tag_q[id_idx]    <= id_tag;
            target_q[id_idx] <= res_target;
            jump_q[id_idx]   <= ID_JumpE_i;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            Stat_branches_o    <= 32'd0;
            Stat_mispredicts_o <= 32'd0;
        end else if (upd_en) begin
            Stat_branches_o <= Stat_branches_o + 32'd1;
            if (mispredict)
                Stat_mispredicts_o <= Stat_mispredicts_o + 32'd1;
        end
    end
`endif
endmodule
